// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster timing source. Divides clk into a pixel enable, scans
// x/y across the full line/frame, and produces registered active-low syncs,
// blanking (video_on) and a frame_start pulse.
// Optional feature macro: VGA_FRAME_CNT_EN adds an 8-bit frame counter port.
module vga_scan_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);

  logic [DIV_W-1:0] div_q, div_d;
  logic             p_tick_q, p_tick_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]       frame_cnt_q, frame_cnt_d;
`endif

  // Next-state: divider, scan counters, and syncs decoded from the next
  // coordinates so sync and x/y change on the same edge.
  always_comb begin
    div_d         = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    p_tick_d      = (div_q == DIV_LAST);
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (p_tick_q) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hsync_d = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
`ifdef VGA_FRAME_CNT_EN
    frame_cnt_d = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      p_tick_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      div_q         <= div_d;
      p_tick_q      <= p_tick_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  // Blanking decoded directly from the registered coordinates.
  always_comb begin
    video_on = (x_q < X_VIS) && (y_q < Y_VIS);
  end

  assign p_tick      = p_tick_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
`ifdef VGA_FRAME_CNT_EN
  assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Testbench for vga_scan_gen using a reduced raster so several frames fit in
// a short run. Expected outputs come from a closed-form position model keyed
// on clocks since reset release.
module tb_vga_scan_gen;

  localparam int CLK_DIV = 4;
  localparam int HD = 20, HF = 4, HS = 6, HB = 5;
  localparam int VD = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;   // 35
  localparam int VT = VD + VF + VS + VB;   // 17
  localparam int FRAME = HT * VT;          // 595 pixels
  localparam int WIN = 2 * FRAME * CLK_DIV; // two whole frames of clks

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p_tick;
  logic [9:0] x, y;
  logic       hsync, vsync, video_on, frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  vga_scan_gen #(
    .CLK_DIV(CLK_DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .p_tick(p_tick), .x(x), .y(y),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .frame_start(frame_start)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int x;
    int y;
    bit pt;
    bit hs;
    bit vs;
    bit von;
    bit fs;
    int fc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mn = 0, mx = 0, my = 0;
  bit   first_run = 1'b1;
  int   hs_low = 0, vs_low = 0, fs_cnt = 0, pt_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model: after reset release, edge n has performed (n-1)/CLK_DIV pixel advances.
  always @(posedge clk) begin
    if (!rst_n) begin
      mn = 0; mx = 0; my = 0;
      q.delete();
    end else begin
      exp_t e;
      int adv, p;
      mn++;
      adv   = (mn - 1) / CLK_DIV;
      p     = adv % FRAME;
      e.n   = mn;
      e.x   = p % HT;
      e.y   = p / HT;
      e.pt  = (mn % CLK_DIV) == 0;
      e.hs  = !(e.x >= HD + HF && e.x <= HD + HF + HS - 1);
      e.vs  = !(e.y >= VD + VF && e.y <= VD + VF + VS - 1);
      e.von = (e.x < HD) && (e.y < VD);
      e.fs  = (adv > 0) && (p == 0) && ((mn - 1) % CLK_DIV == 0);
      e.fc  = (adv / FRAME) % 256;
      mx = e.x; my = e.y;
      q.push_back(e);
    end
  end

  // Compare DUT outputs against the queued expectation away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check_eq("p_tick", {31'd0, p_tick}, {31'd0, e.pt});
      check_eq("x", {22'd0, x}, e.x);
      check_eq("y", {22'd0, y}, e.y);
      check_eq("hsync", {31'd0, hsync}, {31'd0, e.hs});
      check_eq("vsync", {31'd0, vsync}, {31'd0, e.vs});
      check_eq("video_on", {31'd0, video_on}, {31'd0, e.von});
      check_eq("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
`ifdef VGA_FRAME_CNT_EN
      check_eq("frame_cnt", {24'd0, frame_cnt}, e.fc);
`endif
      if (e.x == HD - 1 && e.y == VD - 1) check_eq("von_last_visible", {31'd0, video_on}, 32'd1);
      if (e.x == HD && e.y == 0)          check_eq("von_right_edge", {31'd0, video_on}, 32'd0);
      if (e.x == 0 && e.y == VD)          check_eq("von_bottom_edge", {31'd0, video_on}, 32'd0);
      if (first_run && e.n <= WIN) begin
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
        if (frame_start) fs_cnt++;
        if (p_tick) pt_cnt++;
      end
    end
  end

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_p_tick"}, {31'd0, p_tick}, 32'd0);
    check_eq({pfx, "_x"}, {22'd0, x}, 32'd0);
    check_eq({pfx, "_y"}, {22'd0, y}, 32'd0);
    check_eq({pfx, "_hsync"}, {31'd0, hsync}, 32'd1);
    check_eq({pfx, "_vsync"}, {31'd0, vsync}, 32'd1);
    check_eq({pfx, "_video_on"}, {31'd0, video_on}, 32'd1);
    check_eq({pfx, "_frame_start"}, {31'd0, frame_start}, 32'd0);
`ifdef VGA_FRAME_CNT_EN
    check_eq({pfx, "_frame_cnt"}, {24'd0, frame_cnt}, 32'd0);
`endif
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Two complete frames: syncs, frame_start and p_tick totals.
    for (int i = 0; i < WIN + 10 && mn <= WIN; i++) @(negedge clk);
    first_run = 1'b0;
    check_eq("hsync_low_clks", hs_low, 2 * VT * HS * CLK_DIV);
    check_eq("vsync_low_clks", vs_low, 2 * VS * HT * CLK_DIV);
    check_eq("frame_start_count", fs_cnt, 1);
    check_eq("p_tick_count", pt_cnt, WIN / CLK_DIV);

    // Mid-frame asynchronous reset.
    found = 1'b0;
    for (int i = 0; i < FRAME * CLK_DIV + 10; i++) begin
      @(negedge clk);
      if (x == 10'd10 && y == 10'd5) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reach_mid_frame", {31'd0, found}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("midrst_hold");
    rst_n = 1'b1;

    // Restarted scan is checked cycle by cycle through a full frame.
    repeat (FRAME * CLK_DIV + 20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
